// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulate sequencer.
//   - Group geometry: six 4-bit operands per tree pass, 7-bit tree result.
//   - Controller state encoding.
package csa_pkg;

    localparam int unsigned GROUP_SIZE = 6;
    localparam int unsigned OPER_W     = 4;
    localparam int unsigned TREE_W     = 7;
    // Slot index runs 0..GROUP_SIZE, so it needs room for the value 6.
    localparam int unsigned IDX_W      = 3;

    typedef logic [OPER_W-1:0]           oper_t;
    typedef oper_t [GROUP_SIZE-1:0]      group_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ADD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/csa_accum_sequencer_if.sv
// Job / operand / result bundle for csa_accum_sequencer.
//   start, op_count            : job request (source -> sequencer)
//   in_valid, in_data, in_ready: operand stream (source <-> sequencer)
//   out_valid, out_ready,
//   out_sum, out_overflow      : result handshake (sequencer <-> consumer)
//   busy                       : sequencer not in IDLE
// master = source/consumer side, slave = sequencer side.
interface csa_accum_sequencer_if #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
);
    logic                     start;
    logic [CNT_W-1:0]         op_count;
    logic                     in_valid;
    logic                     in_ready;
    logic [csa_pkg::OPER_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W-1:0]         out_sum;
    logic                     out_overflow;
    logic                     busy;

    modport master (
        output start, op_count, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_overflow, busy
    );

    modport slave (
        input  start, op_count, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_overflow, busy
    );
endinterface

// File: rtl/csa_accum_sequencer_group_buffer.sv
// operand_group_buffer: six operand slots filled in order.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : clear all slots and the write index (wins over write)
//   i_wr_en        : store i_wr_data at the current index, then advance
//   o_slots        : slot contents, unfilled slots read as zero
//   o_idx          : next slot to write (0..GROUP_SIZE)
//   o_full         : all GROUP_SIZE slots written; further writes dropped
module operand_group_buffer
    import csa_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  oper_t             i_wr_data,
    output group_t            o_slots,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_full
);

    group_t           r_slots;
    logic [IDX_W-1:0] r_idx;
    logic             w_full;

    assign w_full = (r_idx == IDX_W'(GROUP_SIZE));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_slots <= '0;
            r_idx   <= '0;
        end else if (i_wr_en && !w_full) begin
            r_slots[r_idx] <= i_wr_data;
            r_idx          <= r_idx + 1'b1;
        end
    end

    assign o_slots = r_slots;
    assign o_idx   = r_idx;
    assign o_full  = w_full;

endmodule

// File: rtl/csa_tree_6x4.sv
// Six-operand 4-bit carry-save adder tree, fully combinational.
//   i_a..i_f : unsigned 4-bit operands
//   o_sum    : 7-bit sum (max 90, so the 7-bit result is exact)
// Three levels of 3:2 compression followed by one carry-propagate add.
module csa_tree_6x4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [3:0] i_c,
    input  logic [3:0] i_d,
    input  logic [3:0] i_e,
    input  logic [3:0] i_f,
    output logic [6:0] o_sum
);

    function automatic logic [6:0] fa_s(input logic [6:0] x, input logic [6:0] y, input logic [6:0] z);
        return x ^ y ^ z;
    endfunction

    // Majority shifted up one bit; the dropped MSB is never set because the
    // true total fits in 7 bits.
    function automatic logic [6:0] fa_c(input logic [6:0] x, input logic [6:0] y, input logic [6:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic [6:0] w_a, w_b, w_c, w_d, w_e, w_f;
    logic [6:0] w_s1, w_c1, w_s2, w_c2, w_s3, w_c3, w_s4, w_c4;

    assign w_a = {3'b000, i_a};
    assign w_b = {3'b000, i_b};
    assign w_c = {3'b000, i_c};
    assign w_d = {3'b000, i_d};
    assign w_e = {3'b000, i_e};
    assign w_f = {3'b000, i_f};

    assign w_s1 = fa_s(w_a, w_b, w_c);
    assign w_c1 = fa_c(w_a, w_b, w_c);
    assign w_s2 = fa_s(w_d, w_e, w_f);
    assign w_c2 = fa_c(w_d, w_e, w_f);

    assign w_s3 = fa_s(w_s1, w_c1, w_s2);
    assign w_c3 = fa_c(w_s1, w_c1, w_s2);

    assign w_s4 = fa_s(w_s3, w_c3, w_c2);
    assign w_c4 = fa_c(w_s3, w_c3, w_c2);

    assign o_sum = w_s4 + w_c4;

endmodule

// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer: sums a stream of 4-bit operands, six at a time,
// through the six-operand carry-save tree into a wide accumulator.
//   clk    : single clock
//   rst_n  : synchronous active-low reset; aborts any job silently
//   bus    : slave side of csa_accum_sequencer_if (job start, operand
//            stream, result handshake, busy)
// Flow: IDLE -> COLLECT (fill up to six slots) -> ADD (acc += tree) ->
// COLLECT again or DONE once every operand has been taken.
module csa_accum_sequencer
    import csa_pkg::*;
#(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    csa_accum_sequencer_if.slave   bus
);

    state_t            r_state;
    logic [CNT_W-1:0]  r_remaining;
    logic [ACC_W-1:0]  r_acc;
    logic              r_overflow;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    group_t            w_slots;
    logic [IDX_W-1:0]  w_idx;
    logic              w_full;
    logic [TREE_W-1:0] w_tree_sum;
    logic              w_start_ok;
    logic              w_accept;
    logic              w_last_accept;
    logic              w_buf_clr;
    logic [ACC_W:0]    w_acc_next;

    assign w_start_ok = (r_state == ST_IDLE) && bus.start;
    assign w_accept   = r_in_ready && bus.in_valid && !w_full;

    // The accept that fills slot 5 or takes the final operand ends the group.
    assign w_last_accept = w_accept &&
                           ((w_idx == IDX_W'(GROUP_SIZE - 1)) ||
                            (r_remaining == CNT_W'(1)));

    assign w_buf_clr  = w_start_ok || (r_state == ST_ADD);

    // One extra bit catches the carry out of the accumulator MSB.
    assign w_acc_next = {1'b0, r_acc} + (ACC_W + 1)'(w_tree_sum);

    operand_group_buffer u_group_buffer (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_clr     (w_buf_clr),
        .i_wr_en   (w_accept),
        .i_wr_data (bus.in_data),
        .o_slots   (w_slots),
        .o_idx     (w_idx),
        .o_full    (w_full)
    );

    csa_tree_6x4 u_tree (
        .i_a   (w_slots[0]),
        .i_b   (w_slots[1]),
        .i_c   (w_slots[2]),
        .i_d   (w_slots[3]),
        .i_e   (w_slots[4]),
        .i_f   (w_slots[5]),
        .o_sum (w_tree_sum)
    );

    // Handshake outputs are registered alongside the state so each one is a
    // direct flop of "next state is X".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_acc       <= '0;
            r_overflow  <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_remaining <= bus.op_count;
                        r_acc       <= '0;
                        r_overflow  <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.op_count == '0) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= ST_COLLECT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end

                ST_COLLECT: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - 1'b1;
                    end
                    if (w_last_accept) begin
                        r_state    <= ST_ADD;
                        r_in_ready <= 1'b0;
                    end
                end

                ST_ADD: begin
                    r_acc      <= w_acc_next[ACC_W-1:0];
                    r_overflow <= r_overflow | w_acc_next[ACC_W];
                    if (r_remaining == '0) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state    <= ST_COLLECT;
                        r_in_ready <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_sum      = r_acc;
    assign bus.out_overflow = r_overflow;
    assign bus.busy         = r_busy;

endmodule
